// File: rtl/ps2_pad_serializer.sv
// ps2_pad_serializer: PS/2 keyboard to active-low 8-button image, replayed serially (load on VSYNC fall, shift on HSYNC rise)
//   CLK, RESET_N      : system clock, asynchronous active-low reset
//   KBCLK, KBDTA      : PS/2 clock and data (asynchronous)
//   HSYNC, VSYNC      : video syncs (asynchronous, VSYNC active low)
//   SER_DATA          : serial button bit, MSB first, 1-filled after 8 shifts
//   BUTTONS           : live image {B,A,Select,Start,Up,Down,Left,Right}, 0 = pressed
//   SCAN_CODE         : last good byte; BYTE_VALID pulses when it updates
//   FRAME_ERR         : pulse on parity, stop or timeout error
module ps2_pad_serializer #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN = 4,
  parameter int TIMEOUT_CYC = 12500
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       KBCLK,
  input  logic       KBDTA,
  input  logic       HSYNC,
  input  logic       VSYNC,
  output logic       SER_DATA,
  output logic [7:0] BUTTONS,
  output logic [7:0] SCAN_CODE,
  output logic       BYTE_VALID,
  output logic       FRAME_ERR
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] kc_s, kd_s, hs_s, vs_s;
  logic [FILT_LEN-1:0] kc_hist;
  logic kc_filt, kc_filt_q, hs_q, vs_q;
  logic [2:0] bit_cnt;
  logic [7:0] rx_sr, shreg;
  logic par_err, e0_seen, f0_seen;
  logic [TW-1:0] tmo;
  logic kd, ps2_fall, hs_rise, vs_fall;
  logic [3:0] key;
  // {valid, bit index} for a completed scan code
  function automatic logic [3:0] key_map(input logic e0, input logic [7:0] code);
    case ({e0, code})
      {1'b1, 8'h74}: return 4'b1000;
      {1'b1, 8'h6B}: return 4'b1001;
      {1'b1, 8'h72}: return 4'b1010;
      {1'b1, 8'h75}: return 4'b1011;
      {1'b0, 8'h0C}: return 4'b1100;
      {1'b0, 8'h04}: return 4'b1101;
      {1'b0, 8'h06}: return 4'b1110;
      {1'b0, 8'h05}: return 4'b1111;
      default:       return 4'b0000;
    endcase
  endfunction
  assign kd = kd_s[SYNC_STAGES-1];
  assign ps2_fall = kc_filt_q & ~kc_filt;
  assign hs_rise = hs_s[SYNC_STAGES-1] & ~hs_q;
  assign vs_fall = ~vs_s[SYNC_STAGES-1] & vs_q;
  assign SER_DATA = shreg[7];
  assign key = key_map(e0_seen, SCAN_CODE);
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      kc_s <= '1;
      kd_s <= '1;
      hs_s <= '1;
      vs_s <= '1;
      kc_hist <= '1;
      kc_filt <= 1'b1;
      kc_filt_q <= 1'b1;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      state <= IDLE;
      bit_cnt <= '0;
      rx_sr <= '0;
      par_err <= 1'b0;
      tmo <= '0;
      e0_seen <= 1'b0;
      f0_seen <= 1'b0;
      BUTTONS <= 8'hFF;
      SCAN_CODE <= 8'h00;
      BYTE_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
      shreg <= 8'hFF;
    end else begin
      kc_s <= {kc_s[SYNC_STAGES-2:0], KBCLK};
      kd_s <= {kd_s[SYNC_STAGES-2:0], KBDTA};
      hs_s <= {hs_s[SYNC_STAGES-2:0], HSYNC};
      vs_s <= {vs_s[SYNC_STAGES-2:0], VSYNC};
      kc_hist <= {kc_hist[FILT_LEN-2:0], kc_s[SYNC_STAGES-1]};
      // filtered level only moves once the whole window agrees
      kc_filt <= (&kc_hist) ? 1'b1 : (~|kc_hist) ? 1'b0 : kc_filt;
      kc_filt_q <= kc_filt;
      hs_q <= hs_s[SYNC_STAGES-1];
      vs_q <= vs_s[SYNC_STAGES-1];
      BYTE_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
      if (ps2_fall) begin
        tmo <= '0;
        case (state)
          IDLE: if (!kd) begin
            state <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            rx_sr <= {kd, rx_sr[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_err <= ~^{rx_sr, kd};
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (kd && !par_err) begin
              SCAN_CODE <= rx_sr;
              BYTE_VALID <= 1'b1;
            end else FRAME_ERR <= 1'b1;
          end
        endcase
      end else if (state != IDLE) begin
        if (tmo == TW'(TIMEOUT_CYC - 1)) begin
          FRAME_ERR <= 1'b1;
          state <= IDLE;
          tmo <= '0;
        end else tmo <= tmo + 1'b1;
      end
      if (FRAME_ERR) begin
        e0_seen <= 1'b0;
        f0_seen <= 1'b0;
      end else if (BYTE_VALID) begin
        if (SCAN_CODE == 8'hE0) e0_seen <= 1'b1;
        else if (SCAN_CODE == 8'hF0) f0_seen <= 1'b1;
        else begin
          if (key[3]) BUTTONS[key[2:0]] <= f0_seen;
          e0_seen <= 1'b0;
          f0_seen <= 1'b0;
        end
      end
      // load has priority so a coincident HSYNC never shifts the fresh snapshot
      if (vs_fall) shreg <= BUTTONS;
      else if (hs_rise) shreg <= {shreg[6:0], 1'b1};
    end
  end
endmodule

// File: tb/tb_ps2_pad_serializer.sv
// tb_ps2_pad_serializer: randomized and directed checks of ps2_pad_serializer against a scan-code/button model
module tb_ps2_pad_serializer;
  localparam int T = 400;
  logic CLK = 1'b0, RESET_N = 1'b0, KBCLK = 1'b1, KBDTA = 1'b1, HSYNC = 1'b0, VSYNC = 1'b1;
  logic SER_DATA, BYTE_VALID, FRAME_ERR;
  logic [7:0] BUTTONS, SCAN_CODE;
  int errors = 0, checks = 0;
  int cyc = 0, bv_cnt = 0, fe_cnt = 0, bv_cyc = 0, fe_cyc = 0, fall_cyc = 0, lat = 0;
  logic [7:0] m_btn = 8'hFF, m_code = 8'h00;
  logic m_e0 = 1'b0, m_f0 = 1'b0;
  logic [7:0] codes [8] = '{8'h74, 8'h6B, 8'h72, 8'h75, 8'h0C, 8'h04, 8'h06, 8'h05};

  ps2_pad_serializer #(.SYNC_STAGES(2), .FILT_LEN(4), .TIMEOUT_CYC(T)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .KBCLK(KBCLK), .KBDTA(KBDTA), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .SER_DATA(SER_DATA), .BUTTONS(BUTTONS), .SCAN_CODE(SCAN_CODE),
    .BYTE_VALID(BYTE_VALID), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;
  always @(negedge CLK) begin
    if (BYTE_VALID) begin bv_cnt++; bv_cyc = cyc; end
    if (FRAME_ERR) begin fe_cnt++; fe_cyc = cyc; end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // button model: E0/F0 prefixes, key table from the pad mapping
  task automatic model_byte(input logic [7:0] d);
    int idx;
    if (d == 8'hE0) m_e0 = 1'b1;
    else if (d == 8'hF0) m_f0 = 1'b1;
    else begin
      idx = -1;
      for (int k = 0; k < 8; k++)
        if (codes[k] == d && (k < 4) == m_e0) idx = k;
      if (idx >= 0) m_btn[idx] = m_f0;
      m_e0 = 1'b0;
      m_f0 = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic b, input logic g);
    KBDTA = b;
    wait_cyc(4);
    KBCLK = 1'b0;
    fall_cyc = cyc;
    wait_cyc(8);
    KBCLK = 1'b1;
    wait_cyc(6);
    if (g) begin
      KBCLK = 1'b0;
      wait_cyc(2);
      KBCLK = 1'b1;
      wait_cyc(4);
    end
  endtask

  task automatic ps2_frame(input logic [7:0] d, input logic bp, input logic bs, input logic g);
    ps2_bit(1'b0, g);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], g);
    ps2_bit((~^d) ^ bp, g);
    ps2_bit(~bs, g);
    KBDTA = 1'b1;
    wait_cyc(12);
    if (bp || bs) begin
      m_e0 = 1'b0;
      m_f0 = 1'b0;
    end else begin
      m_code = d;
      model_byte(d);
    end
  endtask

  task automatic send_key(input int k, input logic rel);
    if (k < 4) ps2_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    if (rel) ps2_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    ps2_frame(codes[k], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hs_pulse;
    HSYNC = 1'b1;
    wait_cyc(6);
    HSYNC = 1'b0;
    wait_cyc(6);
  endtask

  task automatic test_reset;
    wait_cyc(3);
    checks++; if (BUTTONS !== 8'hFF) begin errors++; $display("FAIL rst_buttons: got %h expected ff", BUTTONS); end
    checks++; if (SCAN_CODE !== 8'h00) begin errors++; $display("FAIL rst_scan: got %h expected 00", SCAN_CODE); end
    checks++; if (SER_DATA !== 1'b1) begin errors++; $display("FAIL rst_ser: got %b expected 1", SER_DATA); end
    checks++; if (BYTE_VALID !== 1'b0 || FRAME_ERR !== 1'b0) begin errors++; $display("FAIL rst_pulses: got bv=%b fe=%b expected 0 0", BYTE_VALID, FRAME_ERR); end
    RESET_N = 1'b1;
    wait_cyc(4);
    for (int i = 0; i < 20; i++) begin
      hs_pulse();
      checks++; if (SER_DATA !== 1'b1) begin errors++; $display("FAIL idle_shift %0d: got %b expected 1", i, SER_DATA); end
    end
    checks++; if (bv_cnt != 0 || fe_cnt != 0 || BUTTONS !== 8'hFF) begin errors++; $display("FAIL idle_quiet: got bv=%0d fe=%0d buttons=%h expected 0 0 ff", bv_cnt, fe_cnt, BUTTONS); end
  endtask

  task automatic test_decode;
    logic [7:0] seq [11] = '{8'h06, 8'hF0, 8'h06, 8'hE0, 8'h74, 8'h0C, 8'hE0, 8'hF0, 8'h74, 8'h74, 8'h06};
    logic [7:0] exp [11] = '{8'hBF, 8'hBF, 8'hFF, 8'hFF, 8'hFE, 8'hEE, 8'hEE, 8'hEE, 8'hEF, 8'hEF, 8'hAF};
    int pbv, pfe;
    for (int i = 0; i < 11; i++) begin
      pbv = bv_cnt;
      pfe = fe_cnt;
      ps2_frame(seq[i], 1'b0, 1'b0, 1'b0);
      if (i == 0) begin
        lat = bv_cyc - fall_cyc;
        checks++; if (lat < 2 || lat > 16) begin errors++; $display("FAIL edge_latency: got %0d expected 2..16", lat); end
      end
      checks++; if (bv_cnt != pbv + 1 || fe_cnt != pfe) begin errors++; $display("FAIL dec_pulse %0d: got bv=%0d fe=%0d expected %0d %0d", i, bv_cnt - pbv, fe_cnt - pfe, 1, 0); end
      checks++; if (SCAN_CODE !== seq[i]) begin errors++; $display("FAIL dec_scan %0d: got %h expected %h", i, SCAN_CODE, seq[i]); end
      checks++; if (BUTTONS !== exp[i]) begin errors++; $display("FAIL dec_buttons %0d: got %h expected %h", i, BUTTONS, exp[i]); end
    end
  endtask

  task automatic test_errors;
    int pbv, pfe, f, n;
    pbv = bv_cnt; pfe = fe_cnt;
    ps2_frame(8'h06, 1'b1, 1'b0, 1'b0);
    checks++; if (fe_cnt != pfe + 1 || bv_cnt != pbv) begin errors++; $display("FAIL parity_err: got fe=%0d bv=%0d expected 1 0", fe_cnt - pfe, bv_cnt - pbv); end
    checks++; if (BUTTONS !== m_btn || SCAN_CODE !== m_code) begin errors++; $display("FAIL parity_keep: got %h/%h expected %h/%h", BUTTONS, SCAN_CODE, m_btn, m_code); end
    pbv = bv_cnt; pfe = fe_cnt;
    ps2_frame(8'h0C, 1'b0, 1'b1, 1'b0);
    checks++; if (fe_cnt != pfe + 1 || bv_cnt != pbv || BUTTONS !== m_btn) begin errors++; $display("FAIL stop_err: got fe=%0d bv=%0d btn=%h expected 1 0 %h", fe_cnt - pfe, bv_cnt - pbv, BUTTONS, m_btn); end
    ps2_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    pfe = fe_cnt;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
    f = fall_cyc;
    n = 0;
    while (fe_cnt == pfe && n < T + 100) begin wait_cyc(1); n++; end
    wait_cyc(5);
    m_e0 = 1'b0; m_f0 = 1'b0;
    checks++; if (fe_cnt != pfe + 1) begin errors++; $display("FAIL timeout_count: got %0d expected 1", fe_cnt - pfe); end
    checks++; if (fe_cyc - f != lat + T) begin errors++; $display("FAIL timeout_delay: got %0d expected %0d", fe_cyc - f - lat, T); end
    ps2_frame(8'h74, 1'b0, 1'b0, 1'b0);
    checks++; if (BUTTONS !== m_btn) begin errors++; $display("FAIL timeout_flags: got %h expected %h", BUTTONS, m_btn); end
    pbv = bv_cnt;
    ps2_frame(8'h0C, 1'b0, 1'b0, 1'b0);
    checks++; if (bv_cnt != pbv + 1 || BUTTONS !== m_btn || SCAN_CODE !== 8'h0C) begin errors++; $display("FAIL after_timeout: got bv=%0d btn=%h scan=%h expected 1 %h 0c", bv_cnt - pbv, BUTTONS, SCAN_CODE, m_btn); end
  endtask

  task automatic test_glitch;
    int pbv;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) ps2_frame(8'hF0, 1'b0, 1'b0, 1'b1);
      pbv = bv_cnt;
      ps2_frame(8'h05, 1'b0, 1'b0, 1'b1);
      checks++; if (bv_cnt != pbv + 1 || SCAN_CODE !== 8'h05 || BUTTONS !== m_btn) begin errors++; $display("FAIL glitch %0d: got bv=%0d scan=%h btn=%h expected 1 05 %h", i, bv_cnt - pbv, SCAN_CODE, BUTTONS, m_btn); end
    end
  endtask

  task automatic test_random;
    logic [7:0] bytes [$];
    logic [7:0] d;
    logic bad;
    int k, pbv, pfe;
    for (int it = 0; it < 25; it++) begin
      bytes.delete();
      if ($urandom_range(0, 4) == 0) bytes.push_back(8'($urandom_range(0, 255)));
      k = $urandom_range(0, 7);
      if (k < 4) bytes.push_back(8'hE0);
      if ($urandom_range(0, 1) == 1) bytes.push_back(8'hF0);
      bytes.push_back(codes[k]);
      foreach (bytes[j]) begin
        d = bytes[j];
        bad = ($urandom_range(0, 9) == 0);
        pbv = bv_cnt; pfe = fe_cnt;
        ps2_frame(d, bad, 1'b0, 1'($urandom_range(0, 1)));
        checks++;
        if (bad ? (fe_cnt != pfe + 1 || bv_cnt != pbv) : (bv_cnt != pbv + 1 || fe_cnt != pfe || SCAN_CODE !== d)) begin
          errors++; $display("FAIL rand_frame %0d: got bv=%0d fe=%0d scan=%h expected byte %h bad=%b", it, bv_cnt - pbv, fe_cnt - pfe, SCAN_CODE, d, bad);
        end
        checks++; if (BUTTONS !== m_btn) begin errors++; $display("FAIL rand_buttons %0d: got %h expected %h", it, BUTTONS, m_btn); end
      end
    end
  endtask

  task automatic test_serializer;
    logic ser_exp [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] snap;
    for (int k = 0; k < 8; k++) if (m_btn[k] == 1'b0) send_key(k, 1'b1);
    send_key(6, 1'b0);
    send_key(0, 1'b0);
    checks++; if (BUTTONS !== 8'hBE) begin errors++; $display("FAIL ser_setup: got %h expected be", BUTTONS); end
    VSYNC = 1'b0;
    wait_cyc(6);
    VSYNC = 1'b1;
    wait_cyc(6);
    snap = m_btn;
    checks++; if (SER_DATA !== 1'b1) begin errors++; $display("FAIL ser_load: got %b expected 1", SER_DATA); end
    send_key(7, 1'b0);
    for (int i = 0; i < 9; i++) begin
      hs_pulse();
      snap = {snap[6:0], 1'b1};
      checks++; if (SER_DATA !== ser_exp[i] || SER_DATA !== snap[7]) begin errors++; $display("FAIL ser_shift %0d: got %b expected %b", i, SER_DATA, ser_exp[i]); end
    end
  endtask

  task automatic test_coincident;
    VSYNC = 1'b0;
    HSYNC = 1'b1;
    wait_cyc(6);
    VSYNC = 1'b1;
    HSYNC = 1'b0;
    wait_cyc(6);
    checks++; if (SER_DATA !== m_btn[7]) begin errors++; $display("FAIL coinc_load: got %b expected %b", SER_DATA, m_btn[7]); end
    hs_pulse();
    checks++; if (SER_DATA !== m_btn[6]) begin errors++; $display("FAIL coinc_shift: got %b expected %b", SER_DATA, m_btn[6]); end
  endtask

  task automatic test_reset_mid;
    int pbv, pfe;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
    pbv = bv_cnt; pfe = fe_cnt;
    #3 RESET_N = 1'b0;
    #1;
    checks++; if (BUTTONS !== 8'hFF || SCAN_CODE !== 8'h00 || SER_DATA !== 1'b1 || BYTE_VALID !== 1'b0 || FRAME_ERR !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got btn=%h scan=%h ser=%b bv=%b fe=%b expected ff 00 1 0 0", BUTTONS, SCAN_CODE, SER_DATA, BYTE_VALID, FRAME_ERR);
    end
    wait_cyc(3);
    RESET_N = 1'b1;
    m_btn = 8'hFF; m_code = 8'h00; m_e0 = 1'b0; m_f0 = 1'b0;
    wait_cyc(T + 50);
    checks++; if (bv_cnt != pbv || fe_cnt != pfe) begin errors++; $display("FAIL mid_reset_quiet: got bv=%0d fe=%0d expected 0 0", bv_cnt - pbv, fe_cnt - pfe); end
    ps2_frame(8'h06, 1'b0, 1'b0, 1'b0);
    checks++; if (BUTTONS !== 8'hBF || SCAN_CODE !== 8'h06) begin errors++; $display("FAIL mid_reset_next: got %h/%h expected bf/06", BUTTONS, SCAN_CODE); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_errors();
    test_glitch();
    test_random();
    test_serializer();
    test_coincident();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
